interval_timer_host: RTL and testbench

- Avalon-MM master that drives the system interval timer's 16-bit register slave (addresses 0-5) from hardware, without the CPU.
- Programs the 32-bit period and control, then starts the timer.
- Services its irq by clearing status, and counts ticks.
- Supports stop commands and 32-bit counter snapshot reads.
- Sits beside the timer slave in the system fabric. Hardware logic uses it as a self-maintaining periodic tick source.

---
 rtl/interval_timer_host.sv | 252 +++++++++++++++++++++++++
 tb/tb_interval_timer_host.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer_host.sv
// Avalon-MM master that programs, services and stops the interval timer slave without CPU help.
// Optional feature macro: INTERVAL_TIMER_HOST_TICK_LIMIT_EN (adds tick_limit / limit_hit auto-stop).
module interval_timer_host #(
    parameter int TICK_W     = 32,
    parameter int IRQ_EN_BIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              snap_req,
    input  logic [31:0]       period_value,
    input  logic              continuous,
    input  logic              irq,
`ifdef INTERVAL_TIMER_HOST_TICK_LIMIT_EN
    input  logic [TICK_W-1:0] tick_limit,
    output logic              limit_hit,
`endif
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snapshot_value,
    output logic              snapshot_valid
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_RUN,
        S_WR_STAT,
        S_WR_STOP,
        S_WR_SNAP,
        S_RD_SL,
        S_RD_SH,
        S_CAP
    } state_t;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam logic [15:0] CTRL_STOP = 16'h0008;

    state_t              r_state;
    state_t              w_next;

    logic [31:0]         r_period;
    logic                r_cont;
    logic                r_stop_pend;
    logic [TICK_W-1:0]   r_tick_count;
    logic                r_tick;
    logic                r_busy;
    logic                r_running;
    logic [31:0]         r_snapshot;
    logic                r_snap_valid;

    logic [2:0]          r_av_address;
    logic                r_av_chipselect;
    logic                r_av_write_n;
    logic [15:0]         r_av_writedata;

    logic [31:0]         w_period;
    logic                w_limit_reached;
    logic                w_in_run_group;
    logic [2:0]          w_av_address;
    logic                w_av_chipselect;
    logic                w_av_write_n;
    logic [15:0]         w_av_writedata;

`ifdef INTERVAL_TIMER_HOST_TICK_LIMIT_EN
    logic [TICK_W-1:0]   r_tick_limit;
    logic                r_limit_hit;

    assign w_limit_reached = (r_tick_limit != '0) && (r_tick_count == r_tick_limit);
    assign limit_hit       = r_limit_hit;
`else
    assign w_limit_reached = 1'b0;
`endif

    // The first bus state is entered in the same cycle the period is latched.
    assign w_period = (r_state == S_IDLE) ? period_value : r_period;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_WR_PL;
            S_WR_PL:   w_next = S_WR_PH;
            S_WR_PH:   w_next = S_WR_CTRL;
            S_WR_CTRL: w_next = S_RUN;
            S_RUN: begin
                if (irq)                       w_next = S_WR_STAT;
                else if (stop || r_stop_pend)  w_next = S_WR_STOP;
                else if (snap_req)             w_next = S_WR_SNAP;
            end
            S_WR_STAT: w_next = w_limit_reached ? S_WR_STOP : S_RUN;
            S_WR_STOP: w_next = S_IDLE;
            S_WR_SNAP: w_next = S_RD_SL;
            S_RD_SL:   w_next = S_RD_SH;
            S_RD_SH:   w_next = S_CAP;
            S_CAP:     w_next = S_RUN;
            default:   w_next = S_IDLE;
        endcase
    end

    // NOTE: bus and status outputs are decoded from the next state and registered,
    // so each access is glitch-free and coincides exactly with its state cycle.
    always_comb begin
        w_av_chipselect = 1'b0;
        w_av_write_n    = 1'b1;
        w_av_address    = 3'd0;
        w_av_writedata  = 16'h0000;
        case (w_next)
            S_WR_PL: begin
                w_av_chipselect = 1'b1;
                w_av_write_n    = 1'b0;
                w_av_address    = ADDR_PERIODL;
                w_av_writedata  = w_period[15:0];
            end
            S_WR_PH: begin
                w_av_chipselect = 1'b1;
                w_av_write_n    = 1'b0;
                w_av_address    = ADDR_PERIODH;
                w_av_writedata  = w_period[31:16];
            end
            S_WR_CTRL: begin
                w_av_chipselect = 1'b1;
                w_av_write_n    = 1'b0;
                w_av_address    = ADDR_CONTROL;
                w_av_writedata  = {13'd0, 1'b1, r_cont, 1'(IRQ_EN_BIT)};
            end
            S_WR_STAT: begin
                w_av_chipselect = 1'b1;
                w_av_write_n    = 1'b0;
                w_av_address    = ADDR_STATUS;
            end
            S_WR_STOP: begin
                w_av_chipselect = 1'b1;
                w_av_write_n    = 1'b0;
                w_av_address    = ADDR_CONTROL;
                w_av_writedata  = CTRL_STOP;
            end
            S_WR_SNAP: begin
                w_av_chipselect = 1'b1;
                w_av_write_n    = 1'b0;
                w_av_address    = ADDR_SNAPL;
            end
            S_RD_SL: begin
                w_av_chipselect = 1'b1;
                w_av_address    = ADDR_SNAPL;
            end
            S_RD_SH: begin
                w_av_chipselect = 1'b1;
                w_av_address    = ADDR_SNAPH;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_next)
            S_RUN, S_WR_STAT, S_WR_STOP, S_WR_SNAP,
            S_RD_SL, S_RD_SH, S_CAP: w_in_run_group = 1'b1;
            default:                 w_in_run_group = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_period        <= 32'd0;
            r_cont          <= 1'b0;
            r_stop_pend     <= 1'b0;
            r_tick_count    <= '0;
            r_tick          <= 1'b0;
            r_busy          <= 1'b0;
            r_running       <= 1'b0;
            r_snapshot      <= 32'd0;
            r_snap_valid    <= 1'b0;
            r_av_address    <= 3'd0;
            r_av_chipselect <= 1'b0;
            r_av_write_n    <= 1'b1;
            r_av_writedata  <= 16'h0000;
        end else begin
            r_state         <= w_next;
            r_av_address    <= w_av_address;
            r_av_chipselect <= w_av_chipselect;
            r_av_write_n    <= w_av_write_n;
            r_av_writedata  <= w_av_writedata;
            r_busy          <= (w_next != S_IDLE);
            r_running       <= w_in_run_group;
            r_tick          <= (w_next == S_WR_STAT);
            r_snap_valid    <= (r_state == S_CAP);

            if (r_state == S_IDLE && start) begin
                r_period <= period_value;
                r_cont   <= continuous;
            end

            if (w_next == S_WR_CTRL)
                r_tick_count <= '0;
            else if (w_next == S_WR_STAT)
                r_tick_count <= r_tick_count + 1'b1;

            // A stop that collides with irq waits for the status write to finish.
            if (r_state == S_RUN && irq && stop)
                r_stop_pend <= 1'b1;
            else if (w_next == S_WR_STOP || r_state == S_IDLE)
                r_stop_pend <= 1'b0;

            if (r_state == S_RD_SH)
                r_snapshot[15:0] <= av_readdata;
            if (r_state == S_CAP)
                r_snapshot[31:16] <= av_readdata;
        end
    end

`ifdef INTERVAL_TIMER_HOST_TICK_LIMIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_limit <= '0;
            r_limit_hit  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start)
                r_tick_limit <= tick_limit;
            r_limit_hit <= (r_state == S_WR_STAT) && (w_next == S_WR_STOP);
        end
    end
`endif

    assign av_address     = r_av_address;
    assign av_chipselect  = r_av_chipselect;
    assign av_write_n     = r_av_write_n;
    assign av_writedata   = r_av_writedata;
    assign busy           = r_busy;
    assign running        = r_running;
    assign tick           = r_tick;
    assign tick_count     = r_tick_count;
    assign snapshot_value = r_snapshot;
    assign snapshot_valid = r_snap_valid;

endmodule

// File: tb/tb_interval_timer_host.sv
// Directed self-checking bench for interval_timer_host with a small timer-slave model.
module tb_interval_timer_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        snap_req;
    logic [31:0] period_value;
    logic        continuous;
    logic        irq;
    logic        irq_raise;
    logic [15:0] av_readdata;

    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic        busy;
    logic        running;
    logic        tick;
    logic [31:0] tick_count;
    logic [31:0] snapshot_value;
    logic        snapshot_valid;

    // Narrow-counter twin used only to observe wrap-around.
    logic [2:0]  n_address;
    logic        n_chipselect;
    logic        n_write_n;
    logic [15:0] n_writedata;
    logic        n_busy, n_running, n_tick, n_snap_valid;
    logic [1:0]  n_tick_count;
    logic [31:0] n_snapshot;

`ifdef INTERVAL_TIMER_HOST_TICK_LIMIT_EN
    logic [31:0] tick_limit;
    logic [1:0]  n_tick_limit;
    logic        limit_hit;
    logic        n_limit_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;

    always #5 clk = ~clk;

    interval_timer_host #(.TICK_W(32), .IRQ_EN_BIT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .snap_req(snap_req),
        .period_value(period_value), .continuous(continuous), .irq(irq),
`ifdef INTERVAL_TIMER_HOST_TICK_LIMIT_EN
        .tick_limit(tick_limit), .limit_hit(limit_hit),
`endif
        .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_readdata(av_readdata), .busy(busy),
        .running(running), .tick(tick), .tick_count(tick_count),
        .snapshot_value(snapshot_value), .snapshot_valid(snapshot_valid)
    );

    interval_timer_host #(.TICK_W(2), .IRQ_EN_BIT(1)) dut_narrow (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .snap_req(snap_req),
        .period_value(period_value), .continuous(continuous), .irq(irq),
`ifdef INTERVAL_TIMER_HOST_TICK_LIMIT_EN
        .tick_limit(n_tick_limit), .limit_hit(n_limit_hit),
`endif
        .av_address(n_address), .av_chipselect(n_chipselect), .av_write_n(n_write_n),
        .av_writedata(n_writedata), .av_readdata(av_readdata), .busy(n_busy),
        .running(n_running), .tick(n_tick), .tick_count(n_tick_count),
        .snapshot_value(n_snapshot), .snapshot_valid(n_snap_valid)
    );

    // Timer slave model: irq clears one cycle after a status write; registered reads.
    always @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else if (av_chipselect && !av_write_n && av_address == 3'd0)
            irq <= 1'b0;
        else if (irq_raise)
            irq <= 1'b1;
        if (av_chipselect && av_write_n)
            av_readdata <= (av_address == 3'd4) ? 16'h1234 :
                           (av_address == 3'd5) ? 16'h0056 : 16'h0000;
    end

    always @(posedge clk)
        if (snapshot_valid) n_valid++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic cs, input logic wr_n,
                             input logic [2:0] addr, input logic [15:0] data);
        check(tag, {av_chipselect, av_write_n, av_address, av_writedata},
                   {cs, wr_n, addr, data});
    endtask

    // Raise irq, then confirm the status write, tick pulse and count on entry to WR_STAT.
    task automatic service_irq(input string tag, input logic [31:0] exp_count);
        irq_raise = 1'b1;
        step();
        irq_raise = 1'b0;
        step();
        check_bus({tag, "_stat_wr"}, 1'b1, 1'b0, 3'd0, 16'h0000);
        check({tag, "_tick"}, tick, 1'b1);
        check({tag, "_count"}, tick_count, exp_count);
        check({tag, "_count_narrow"}, n_tick_count, exp_count[1:0]);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        snap_req     = 1'b0;
        period_value = 32'd0;
        continuous   = 1'b0;
        irq_raise    = 1'b0;
`ifdef INTERVAL_TIMER_HOST_TICK_LIMIT_EN
        tick_limit   = 32'd0;
        n_tick_limit = 2'd0;
`endif
        step();
        step();
        check_bus("rst_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
        check("rst_flags", {busy, running, tick, snapshot_valid}, 4'b0000);
        check("rst_count", tick_count, 32'd0);
        check("rst_snap", snapshot_value, 32'd0);
        reset = 1'b0;

        // stop / snap_req in IDLE are dropped
        stop = 1'b1; snap_req = 1'b1;
        step();
        stop = 1'b0; snap_req = 1'b0;
        check("idle_ignore_busy", busy, 1'b0);
        check_bus("idle_ignore_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
        step();
        check("idle_ignore_busy2", busy, 1'b0);

        // programming sequence, continuous mode
        period_value = 32'h0001_86A0; continuous = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check_bus("wr_pl", 1'b1, 1'b0, 3'd2, 16'h86A0);
        check("wr_pl_busy", busy, 1'b1);
        step();
        check_bus("wr_ph", 1'b1, 1'b0, 3'd3, 16'h0001);
        step();
        check_bus("wr_ctrl", 1'b1, 1'b0, 3'd1, 16'h0007);
        step();
        check_bus("run_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
        check("run_running", running, 1'b1);
        check("run_count0", tick_count, 32'd0);

        // four timeouts; the 2-bit twin wraps back to 0
        for (int i = 1; i <= 4; i++) begin
            service_irq("tick", 32'(i));
            check("tick_low", tick, 1'b0);
            check_bus("tick_back_run", 1'b0, 1'b1, 3'd0, 16'h0000);
        end
        check("wrap_narrow", n_tick_count, 2'd0);

        // counter snapshot
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        check("snap_wr", {av_chipselect, av_write_n, av_address}, {1'b1, 1'b0, 3'd4});
        step();
        check("snap_rd_lo", {av_chipselect, av_write_n, av_address}, {1'b1, 1'b1, 3'd4});
        step();
        check("snap_rd_hi", {av_chipselect, av_write_n, av_address}, {1'b1, 1'b1, 3'd5});
        step();
        check("snap_cap_bus", {av_chipselect, av_write_n}, 2'b01);
        check("snap_cap_valid", snapshot_valid, 1'b0);
        step();
        check("snap_value", snapshot_value, 32'h0056_1234);
        check("snap_valid", snapshot_valid, 1'b1);
        step();
        check("snap_valid_low", snapshot_valid, 1'b0);
        check("snap_valid_count", n_valid, 1);

        // irq and stop in the same RUN cycle
        irq_raise = 1'b1;
        step();
        irq_raise = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_bus("coll_stat_wr", 1'b1, 1'b0, 3'd0, 16'h0000);
        check("coll_count", tick_count, 32'd5);
        step();
        check_bus("coll_run", 1'b0, 1'b1, 3'd0, 16'h0000);
        step();
        check_bus("coll_stop_wr", 1'b1, 1'b0, 3'd1, 16'h0008);
        step();
        check("coll_idle", {busy, running}, 2'b00);
        check("coll_count_kept", tick_count, 32'd5);
        check_bus("coll_idle_bus", 1'b0, 1'b1, 3'd0, 16'h0000);

        // reset during WR_PH
        period_value = 32'h0002_0003; continuous = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_bus("rmid_wr_ph", 1'b1, 1'b0, 3'd3, 16'h0002);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_bus("rmid_bus_idle", 1'b0, 1'b1, 3'd0, 16'h0000);
        check("rmid_busy", busy, 1'b0);

        // restart, one-shot; a second start held during the sequence is ignored
        start = 1'b1;
        step();
        check_bus("re_wr_pl", 1'b1, 1'b0, 3'd2, 16'h0003);
        period_value = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        check_bus("re_wr_ph", 1'b1, 1'b0, 3'd3, 16'h0002);
        step();
        check_bus("re_wr_ctrl", 1'b1, 1'b0, 3'd1, 16'h0005);
        step();
        check("re_running", running, 1'b1);
        service_irq("oneshot", 32'd1);
        step(); step(); step();
        check("oneshot_stays", {busy, running}, 2'b11);
        check_bus("oneshot_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_bus("oneshot_stop_wr", 1'b1, 1'b0, 3'd1, 16'h0008);
        step();
        check("oneshot_idle", busy, 1'b0);
        check("oneshot_count_kept", tick_count, 32'd1);

`ifdef INTERVAL_TIMER_HOST_TICK_LIMIT_EN
        // automatic stop on reaching tick_limit
        tick_limit = 32'd2; n_tick_limit = 2'd2;
        period_value = 32'h0000_0010; continuous = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        tick_limit = 32'd0; n_tick_limit = 2'd0;
        step(); step(); step();
        check("lim_running", running, 1'b1);
        service_irq("lim1", 32'd1);
        check_bus("lim1_run", 1'b0, 1'b1, 3'd0, 16'h0000);
        irq_raise = 1'b1;
        step();
        irq_raise = 1'b0;
        step();
        check("lim2_count", tick_count, 32'd2);
        check("lim2_hit_low", limit_hit, 1'b0);
        step();
        check_bus("lim_stop_wr", 1'b1, 1'b0, 3'd1, 16'h0008);
        check("lim_hit", limit_hit, 1'b1);
        step();
        check("lim_idle", busy, 1'b0);
        check("lim_hit_low", limit_hit, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
